aes_inv_round_iter: RTL and testbench
=====================================

Name: aes_inv_round_iter

Overview:
- Iterative AES-128 inverse cipher datapath: one round per clock, 11 round-key applications per block.
- Decryption counterpart of the forward round path. Built around InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
- Sits between the ciphertext input buffer and the plaintext output stage.
- Round keys come from the external round-key store through a same-cycle index/data lookup.

Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported).
- RKI_W, 4, width of the round-key index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext valid.
- in_ready  output  1  block can accept ciphertext (high only in IDLE).
- ct  input  128  ciphertext; bits [127:120] = byte 0 (row 0, col 0); column-major byte order.
- rk_idx  output  RKI_W  round-key index requested this cycle.
- rk  input  128  round key for rk_idx, combinational from the key store, same byte order as ct.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  downstream accepts plaintext.
- pt  output  128  plaintext (the state register).
- busy  output  1  high in ROUND, FINAL and DONE.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, state register (pt)=0, round counter=NR-1, out_valid=0, busy=0. in_ready=1 in the first cycle after reset.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - rk_idx=NR; in_ready=1.
  - On in_valid&&in_ready: state_reg <= ct ^ rk (initial AddRoundKey); round counter <= NR-1; go to ROUND.
- ROUND:
  - rk_idx = round counter (9 down to 1).
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk).
  - Counter decrements each cycle. When counter==1, go to FINAL.
- FINAL:
  - rk_idx=0.
  - state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ rk (no InvMixColumns).
  - Go to DONE.
- DONE:
  - out_valid=1; pt stable.
  - On out_ready: go to IDLE and drop out_valid.
  - in_ready stays low until that IDLE cycle. There is no overlap of blocks.
- Latency: out_valid rises on the 10th rising edge after the accepting edge. 11 key applications total. Throughput is one block per 11 cycles minimum (12 including the IDLE accept cycle).
- InvShiftRows: row r is rotated right by r columns, s'(r,c)=s(r,(c-r) mod 4).
  - Example: out byte 1 = in byte 13 (bits [119:112] <= [23:16]).
  - Row 0 is unchanged.
- InvMixColumns: per column, matrix [0e 0b 0d 09] circulant, GF(2^8) with polynomial 0x11B.
- InvSubBytes: FIPS-197 inverse S-box on all 16 bytes.
- rk_idx: combinational from the FSM and counter. rk is sampled in the same cycle.
- Boundary conditions:
  - in_valid while busy: ignored, no side effect, ct not captured.
  - out_ready held high before DONE: no effect. In DONE it completes the transfer in one cycle.
  - out_ready low: DONE holds indefinitely; pt and out_valid are stable.
  - rst in any state: aborts immediately; next cycle is IDLE with pt=0 and out_valid=0.
  - in_valid and out_ready both high in DONE: the output transfer completes. The new ct is not accepted until the following IDLE cycle.
  - Round counter never wraps below 1 in ROUND. Entering ROUND with NR-1 gives exactly 9 ROUND cycles.

Decomposition:
- Shared package: AES_NR=10, AES_BLK_W=128, byte-index/column helper constants, GF reduction constant 8'h1B.
- Sub-module inv_sbox:
  - 8-bit in, 8-bit out, combinational.
  - ROM or composite-field implementation; the result must match FIPS-197.
  - Instantiated 16 times.
- InvShiftRows and InvMixColumns (xtime chain): inline functions in this module.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: key store loaded with the expansion of key 000102030405060708090a0b0c0d0e0f (rk10=13111d7fe3944a17f307a78b4d2b30c5); ct=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: pt=00112233445566778899aabbccddeeff; out_valid on the 10th edge after accept.
  - Check the rk_idx sequence 10,9,…,1,0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> pt constant, in_ready=0, busy=1. Raise out_ready -> out_valid drops next cycle, in_ready=1.
- in_valid asserted continuously with a second ct during processing -> first result unaffected. Second block accepted only in the IDLE cycle after DONE; its result is correct.
- Reset asserted in ROUND at rk_idx=5 -> next cycle IDLE, pt=0, out_valid=0. A subsequent C.1 block decrypts correctly.
- Back-to-back: 50 random key/plaintext pairs encrypted by the reference model -> all decrypt to the original plaintext. Spacing is exactly 12 cycles with out_ready tied high.
- inv_sbox unit check: inputs 0x63->0x00, 0x7c->0x01, 0x16->0xff. All 256 entries are the inverse of the forward S-box.

Source files
------------

// File: rtl/aes_inv_round_iter_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the iterative AES-128 inverse cipher.
package aes_inv_round_iter_pkg;

    localparam int unsigned AES_NR        = 10;
    localparam int unsigned AES_BLK_W     = 128;
    localparam int unsigned AES_RKI_W     = 4;
    localparam int unsigned AES_BYTE_W    = 8;
    localparam int unsigned AES_NUM_BYTES = 16;
    localparam int unsigned AES_NUM_ROWS  = 4;
    localparam int unsigned AES_NUM_COLS  = 4;
    localparam logic [7:0]  AES_GF_RED    = 8'h1B;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StFinal,
        StDone
    } aes_state_e;

    // Byte 0 sits in the top byte of the block; bytes run column-major.
    function automatic int byte_msb(input int idx);
        return int'(AES_BLK_W) - 1 - int'(AES_BYTE_W) * idx;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_GF_RED : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round_iter_if.sv
// Ciphertext-in / key-lookup / plaintext-out bundle of the inverse round engine.
interface aes_inv_round_iter_if
    import aes_inv_round_iter_pkg::*;
#(
    parameter int unsigned RKI_W = AES_RKI_W
);

    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] ct;
    logic [RKI_W-1:0]     rk_idx;
    logic [AES_BLK_W-1:0] rk;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] pt;
    logic                 busy;

    modport master (
        output in_valid,
        output ct,
        output rk,
        output out_ready,
        input  in_ready,
        input  rk_idx,
        input  out_valid,
        input  pt,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  ct,
        input  rk,
        input  out_ready,
        output in_ready,
        output rk_idx,
        output out_valid,
        output pt,
        output busy
    );

endinterface

// File: rtl/aes_inv_round_iter_inv_sbox.sv
// FIPS-197 inverse S-box: inverse affine transform followed by GF(2^8) inversion.
module aes_inv_round_iter_inv_sbox
    import aes_inv_round_iter_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    logic [7:0] pre_inv;

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    assign pre_inv = {data_i[6:0], data_i[7]}
                   ^ {data_i[4:0], data_i[7:5]}
                   ^ {data_i[1:0], data_i[7:2]}
                   ^ 8'h05;

    assign data_o = gf_inv(pre_inv);

endmodule

// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 inverse cipher: initial AddRoundKey on accept, then one round per clock.
module aes_inv_round_iter
    import aes_inv_round_iter_pkg::*;
#(
    parameter int unsigned NR    = AES_NR,
    parameter int unsigned RKI_W = AES_RKI_W
) (
    input logic                 clk,
    input logic                 rst,
    aes_inv_round_iter_if.slave bus
);

    function automatic logic [AES_BLK_W-1:0] inv_shift_rows(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < int'(AES_NUM_COLS); c++) begin
            for (int r = 0; r < int'(AES_NUM_ROWS); r++) begin
                o[byte_msb(4 * c + r) -: 8] = s[byte_msb(4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [AES_BLK_W-1:0] inv_mix_columns(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] o;
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        o = '0;
        for (int c = 0; c < int'(AES_NUM_COLS); c++) begin
            for (int r = 0; r < 4; r++) begin
                a     = s[byte_msb(4 * c + r) -: 8];
                x2    = xtime(a);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a;
                mb[r] = x8 ^ x2 ^ a;
                md[r] = x8 ^ x4 ^ a;
                me[r] = x8 ^ x4 ^ x2;
            end
            for (int r = 0; r < 4; r++) begin
                o[byte_msb(4 * c + r) -: 8] =
                    me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
            end
        end
        return o;
    endfunction

    aes_state_e           state_q, state_d;
    logic [AES_BLK_W-1:0] state_reg_q, state_reg_d;
    logic [RKI_W-1:0]     cnt_q, cnt_d;
    logic [RKI_W-1:0]     rk_idx;
    logic                 in_ready, out_valid, busy;
    logic [AES_BLK_W-1:0] shifted, subbed, added;

    assign shifted = inv_shift_rows(state_reg_q);

    for (genvar i = 0; i < AES_NUM_BYTES; i++) begin : g_sbox
        aes_inv_round_iter_inv_sbox u_inv_sbox (
            .data_i (shifted[AES_BLK_W-1-8*i -: 8]),
            .data_o (subbed[AES_BLK_W-1-8*i -: 8])
        );
    end

    assign added = subbed ^ bus.rk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            state_reg_q <= '0;
            cnt_q       <= RKI_W'(NR - 1);
        end else begin
            state_q     <= state_d;
            state_reg_q <= state_reg_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        state_reg_d = state_reg_q;
        cnt_d       = cnt_q;
        rk_idx      = '0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            StIdle: begin
                rk_idx   = RKI_W'(NR);
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_reg_d = bus.ct ^ bus.rk;
                    cnt_d       = RKI_W'(NR - 1);
                    state_d     = StRound;
                end
            end
            StRound: begin
                busy        = 1'b1;
                rk_idx      = cnt_q;
                state_reg_d = inv_mix_columns(added);
                cnt_d       = cnt_q - 1'b1;
                if (cnt_q == RKI_W'(1)) state_d = StFinal;
            end
            StFinal: begin
                busy        = 1'b1;
                rk_idx      = '0;
                state_reg_d = added;
                state_d     = StDone;
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.rk_idx    = rk_idx;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.pt        = state_reg_q;

endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Self-checking bench: forward AES-128 reference model encrypts, the DUT must recover the plaintext.
module tb_aes_inv_round_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;

    logic [7:0]   sbox     [256];
    logic [7:0]   isbox    [256];
    logic [127:0] rk_store [16];
    logic [7:0]   sb_in;
    logic [7:0]   sb_out;

    aes_inv_round_iter_if bus ();

    aes_inv_round_iter #(
        .NR    (10),
        .RKI_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    aes_inv_round_iter_inv_sbox u_sb (
        .data_i (sb_in),
        .data_o (sb_out)
    );

    // Same-cycle key store lookup.
    assign bus.rk = rk_store[bus.rk_idx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward S-box from a brute-force field inverse plus the forward affine map.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_store[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [7:0]   s [16];
        logic [7:0]   n [16];
        logic [7:0]   a [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8 * i -: 8] ^ rk_store[0][127 - 8 * i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) n[4 * c + r] = s[4 * ((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = n[4 * c + r];
                    for (int r = 0; r < 4; r++)
                        n[4 * c + r] = gmul(a[r], 8'h02) ^ gmul(a[(r + 1) % 4], 8'h03)
                                     ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = n[i] ^ rk_store[rnd][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.pt !== 128'h0) begin
            n_fail++; $display("FAIL reset_pt: got %h want 0", bus.pt);
        end
        n_checks++;
        if (bus.rk_idx !== 4'd10) begin
            n_fail++; $display("FAIL reset_rk_idx: got %0d want 10", bus.rk_idx);
        end
    endtask

    task automatic test_fips();
        load_key(C1_KEY);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ct       = C1_CT;
        n_checks++;
        if (bus.rk_idx !== 4'd10) begin
            n_fail++; $display("FAIL fips_rk_idx_idle: got %0d want 10", bus.rk_idx);
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            n_checks++;
            if (bus.rk_idx !== 4'(10 - k)) begin
                n_fail++; $display("FAIL fips_rk_idx step %0d: got %0d want %0d", k, bus.rk_idx, 10 - k);
            end
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL fips_early_valid step %0d: got %b want 0", k, bus.out_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL fips_latency: got out_valid %b want 1", bus.out_valid);
        end
        n_checks++;
        if (bus.pt !== C1_PT) begin
            n_fail++; $display("FAIL fips_pt: got %h want %h", bus.pt, C1_PT);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL fips_release: got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] p;
        load_key(rand128());
        p = rand128();
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ct       = encrypt(p);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 30 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_wait: got out_valid %b want 1", bus.out_valid);
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (bus.pt !== p || bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold cycle %0d: got pt %h valid %b want %h 1", i, bus.pt, bus.out_valid, p);
            end
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL bp_flags cycle %0d: got ready %b busy %b want 0 1", i, bus.in_ready, bus.busy);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_in_valid_busy();
        logic [127:0] p1, p2;
        int t1;
        load_key(rand128());
        p1 = rand128();
        p2 = rand128();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ct       = encrypt(p1);
        @(negedge clk);
        bus.ct = encrypt(p2);
        for (int i = 0; i < 30 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        t1 = cyc;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.pt !== p1) begin
            n_fail++; $display("FAIL busy_first_pt: got valid %b pt %h want 1 %h", bus.out_valid, bus.pt, p1);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL busy_done_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL busy_idle_ready: got %b want 1", bus.in_ready);
        end
        for (int i = 0; i < 30 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.pt !== p2) begin
            n_fail++; $display("FAIL busy_second_pt: got valid %b pt %h want 1 %h", bus.out_valid, bus.pt, p2);
        end
        n_checks++;
        if (cyc - t1 != 12) begin
            n_fail++; $display("FAIL busy_spacing: got %0d cycles want 12", cyc - t1);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midround();
        load_key(C1_KEY);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ct       = C1_CT;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && bus.rk_idx !== 4'd5; i++) @(negedge clk);
        n_checks++;
        if (bus.rk_idx !== 4'd5 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_reach_round5: got idx %0d busy %b want 5 1", bus.rk_idx, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.pt !== 128'h0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_clear: got pt %h valid %b want 0 0", bus.pt, bus.out_valid);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rk_idx !== 4'd10) begin
            n_fail++; $display("FAIL rst_mid_idle: got ready %b busy %b idx %0d want 1 0 10", bus.in_ready, bus.busy, bus.rk_idx);
        end
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 30 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.pt !== C1_PT) begin
            n_fail++; $display("FAIL rst_mid_redo: got valid %b pt %h want 1 %h", bus.out_valid, bus.pt, C1_PT);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] p_cur;
        int t_prev;
        bus.out_ready = 1'b1;
        @(negedge clk);
        load_key(rand128());
        p_cur        = rand128();
        bus.ct       = encrypt(p_cur);
        bus.in_valid = 1'b1;
        t_prev       = 0;
        for (int j = 0; j < 50; j++) begin
            for (int i = 0; i < 30 && bus.out_valid !== 1'b1; i++) @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.pt !== p_cur) begin
                n_fail++; $display("FAIL b2b_pt block %0d: got valid %b pt %h want 1 %h", j, bus.out_valid, bus.pt, p_cur);
            end
            if (j > 0) begin
                n_checks++;
                if (cyc - t_prev != 12) begin
                    n_fail++; $display("FAIL b2b_spacing block %0d: got %0d want 12", j, cyc - t_prev);
                end
            end
            t_prev = cyc;
            if (j < 49) begin
                load_key(rand128());
                p_cur  = rand128();
                bus.ct = encrypt(p_cur);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_inv_sbox();
        sb_in = 8'h63;
        #1;
        n_checks++;
        if (sb_out !== 8'h00) begin
            n_fail++; $display("FAIL sbox_63: got %h want 00", sb_out);
        end
        sb_in = 8'h7c;
        #1;
        n_checks++;
        if (sb_out !== 8'h01) begin
            n_fail++; $display("FAIL sbox_7c: got %h want 01", sb_out);
        end
        sb_in = 8'h16;
        #1;
        n_checks++;
        if (sb_out !== 8'hff) begin
            n_fail++; $display("FAIL sbox_16: got %h want ff", sb_out);
        end
        for (int v = 0; v < 256; v++) begin
            sb_in = 8'(v);
            #1;
            n_checks++;
            if (sb_out !== isbox[v]) begin
                n_fail++; $display("FAIL sbox_table in %h: got %h want %h", v[7:0], sb_out, isbox[v]);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rst           = 1'b1;
        sb_in         = 8'h00;
        bus.in_valid  = 1'b0;
        bus.ct        = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) rk_store[i] = '0;
        build_tables();
        test_reset();
        test_fips();
        test_backpressure();
        test_in_valid_busy();
        test_reset_midround();
        test_back_to_back();
        test_inv_sbox();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
